// File: rtl/ccd_vtiming_pkg.sv
// Shared constants for the CXD3400 vertical-timing sequencer: FSM state codes,
// XV idle level and the 4-phase vertical-transfer pattern.
package ccd_vtiming_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SG_PRE   = 3'd1;
  localparam state_t ST_SG_PULSE = 3'd2;
  localparam state_t ST_SG_POST  = 3'd3;
  localparam state_t ST_OFD      = 3'd4;
  localparam state_t ST_VSHIFT   = 3'd5;
  localparam state_t ST_DONE     = 3'd6;

  localparam logic [3:0] XV_IDLE = 4'b1100;

  // Entry 0 sits in the LSBs; consecutive entries differ in exactly one bit.
  localparam logic [31:0] XV_TABLE = {4'b0100, 4'b0110, 4'b0010, 4'b0011,
                                      4'b0001, 4'b1001, 4'b1000, 4'b1100};

  function automatic logic [3:0] xv_pattern(input logic [2:0] idx);
    return XV_TABLE[{idx, 2'b00} +: 4];
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/ccd_xv_seq.sv
// 4-phase XV step generator: walks the 8-entry pattern once per line, holding
// each entry for PHASE_CLKS cycles, for a line count captured at start.
module ccd_xv_seq
  import ccd_vtiming_pkg::*;
#(
  parameter int PHASE_CLKS = 4,
  parameter int LINE_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LINE_W-1:0] line_num,
  output logic [3:0]        xv,
  output logic              line_done,
  output logic              seq_done
);

  localparam int STEP_W = cnt_width(PHASE_CLKS);
  localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(PHASE_CLKS - 1);

  logic              active;
  logic [2:0]        phase;
  logic [STEP_W-1:0] step;
  logic [LINE_W-1:0] lines;
  logic              step_end;

  assign step_end  = active && (step == '0);
  assign line_done = step_end && (phase == 3'd7);
  assign seq_done  = line_done && (lines == LINE_W'(1));
  assign xv        = active ? xv_pattern(phase) : XV_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      phase  <= 3'd0;
      step   <= '0;
      lines  <= '0;
    end else if (start) begin
      // A zero line count never activates, so the pins stay at XV_IDLE.
      active <= (line_num != '0);
      phase  <= 3'd0;
      step   <= STEP_RELOAD;
      lines  <= line_num;
    end else if (step_end) begin
      step  <= STEP_RELOAD;
      phase <= phase + 3'd1;
      if (line_done) begin
        lines <= lines - LINE_W'(1);
        if (seq_done) active <= 1'b0;
      end
    end else if (active) begin
      step <= step - STEP_W'(1);
    end
  end

endmodule

// File: rtl/ccd_vtiming_ctrl.sv
// CXD3400 vertical-driver sequencer: arbitrates readout / shutter / vertical
// shift requests and drives XV[3:0], XSG and OFD from registered outputs.
module ccd_vtiming_ctrl
  import ccd_vtiming_pkg::*;
#(
  parameter int PHASE_CLKS = 4,
  parameter int XSG_GUARD  = 8,
  parameter int XSG_CLKS   = 40,
  parameter int OFD_CLKS   = 20,
  parameter int LINE_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_readout_req,
  input  logic              i_ofd_req,
  input  logic              i_vshift_req,
  input  logic [LINE_W-1:0] iv_line_num,
  output logic [3:0]        ov_xv,
  output logic              o_xsg,
  output logic              o_ofd,
  output logic              o_busy,
  output logic              o_done
);

  localparam int TMR_MAX = (XSG_GUARD > XSG_CLKS) ?
                           ((XSG_GUARD > OFD_CLKS) ? XSG_GUARD : OFD_CLKS) :
                           ((XSG_CLKS  > OFD_CLKS) ? XSG_CLKS  : OFD_CLKS);
  localparam int TMR_W = cnt_width(TMR_MAX);

  localparam logic [TMR_W-1:0] GUARD_LD = TMR_W'(XSG_GUARD - 1);
  localparam logic [TMR_W-1:0] XSG_LD   = TMR_W'(XSG_CLKS - 1);
  localparam logic [TMR_W-1:0] OFD_LD   = TMR_W'(OFD_CLKS - 1);

  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] tmr;
  logic             tmr_zero;
  logic             seq_start;
  logic [3:0]       seq_xv;
  logic             seq_line_done;
  logic             seq_done;

  logic [3:0]       xv_p1;
  logic             xsg_p1;
  logic             ofd_p1;
  logic             busy_p1;
  logic             done_p1;

  assign tmr_zero  = (tmr == '0);
  assign seq_start = (state == ST_IDLE) && !i_readout_req && !i_ofd_req && i_vshift_req;

  ccd_xv_seq #(
    .PHASE_CLKS (PHASE_CLKS),
    .LINE_W     (LINE_W)
  ) u_xv_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (seq_start),
    .line_num  (iv_line_num),
    .xv        (seq_xv),
    .line_done (seq_line_done),
    .seq_done  (seq_done)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_readout_req)     next_state = ST_SG_PRE;
        else if (i_ofd_req)    next_state = ST_OFD;
        else if (i_vshift_req) next_state = (iv_line_num == '0) ? ST_DONE : ST_VSHIFT;
      end
      ST_SG_PRE:   if (tmr_zero) next_state = ST_SG_PULSE;
      ST_SG_PULSE: if (tmr_zero) next_state = ST_SG_POST;
      ST_SG_POST:  if (tmr_zero) next_state = ST_DONE;
      ST_OFD:      if (tmr_zero) next_state = ST_DONE;
      ST_VSHIFT:   if (seq_done) next_state = ST_DONE;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Stage p0: state register and dwell timer, loaded on every state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        case (next_state)
          ST_SG_PRE,
          ST_SG_POST:  tmr <= GUARD_LD;
          ST_SG_PULSE: tmr <= XSG_LD;
          ST_OFD:      tmr <= OFD_LD;
          default:     tmr <= '0;
        endcase
      end else if (!tmr_zero) begin
        tmr <= tmr - TMR_W'(1);
      end
    end
  end

  // Stage p1: pin registers decoded from the current state, one cycle behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xv_p1   <= XV_IDLE;
      xsg_p1  <= 1'b1;
      ofd_p1  <= 1'b1;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      xv_p1   <= (state == ST_VSHIFT) ? seq_xv : XV_IDLE;
      xsg_p1  <= (state != ST_SG_PULSE);
      ofd_p1  <= (state != ST_OFD);
      busy_p1 <= (state != ST_IDLE) || (next_state != ST_IDLE);
      done_p1 <= (state == ST_DONE);
    end
  end

  assign ov_xv  = xv_p1;
  assign o_xsg  = xsg_p1;
  assign o_ofd  = ofd_p1;
  assign o_busy = busy_p1;
  assign o_done = done_p1;

  // The shift may only finish on the last step of a line.
  assert property (@(posedge clk) disable iff (reset) seq_done |-> seq_line_done);

endmodule
